display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Scans a multiplexed seven-segment display. Each digit gets a dead-time
// BLANK period (all anodes and segments off) followed by a DRIVE period
// (one anode low, decoded segments on). At the start of every frame, the
// block takes a snapshot of the source selection, digits and decimal-point
// mask. A whole frame is therefore drawn from a single source, so changes
// made part-way through a frame cannot mix two sources on the display.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   live_digits  live tuner digits, digit i at [3i+2:3i]
//   live_valid   live_digits meaningful
//   file_digits  file-playback digits, same packing
//   file_valid   file_digits meaningful (has priority over live)
//   dp_mask      bit i lights the decimal point of digit i
//   seg_out      active-low segments, bit7 = DP, bits[6:0] = g..a
//   an_out       active-low digit anodes
//   src_sel      source of current frame: 00 none, 01 live, 10 file
//   frame_done   one-cycle pulse after the last DRIVE clock of a frame
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3*NUM_DIGITS-1:0] live_digits,
  input  logic                    live_valid,
  input  logic [3*NUM_DIGITS-1:0] file_digits,
  input  logic                    file_valid,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [1:0]              src_sel,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_LIVE = 2'b01;
  localparam logic [1:0] SRC_FILE = 2'b10;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              src_q, src_d;
  logic [3*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  // Segment pattern for digits 0..7, active low, with the DP bit off.
  function automatic logic [7:0] decode_digit(input logic [2:0] d);
    logic [7:0] seg;
    case (d)
      3'd0:    seg = 8'hC0;
      3'd1:    seg = 8'hF9;
      3'd2:    seg = 8'hA4;
      3'd3:    seg = 8'hB0;
      3'd4:    seg = 8'h99;
      3'd5:    seg = 8'h92;
      3'd6:    seg = 8'h82;
      default: seg = 8'hF8;
    endcase
    return seg;
  endfunction

  // Next-state logic for the scan state machine, the snapshot, and the
  // registered outputs. The outputs are computed from the current state,
  // so they lag the state/counter by one clock.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + 1'b1;
    src_d        = src_q;
    digits_d     = digits_q;
    dp_d         = dp_q;
    seg_d        = 8'hFF;
    an_d         = '1;
    frame_done_d = 1'b0;

    // The frame snapshot is taken on the first BLANK clock of digit 0 only.
    if (state_q == ST_BLANK && idx_q == '0 && cnt_q == '0) begin
      dp_d = dp_mask;
      if (file_valid) begin
        src_d    = SRC_FILE;
        digits_d = file_digits;
      end else if (live_valid) begin
        src_d    = SRC_LIVE;
        digits_d = live_digits;
      end else begin
        src_d    = SRC_NONE;
        digits_d = '0;
      end
    end

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        an_d[idx_q] = 1'b0;
        if (src_q != SRC_NONE) begin
          seg_d = decode_digit(digits_q[idx_q*3 +: 3]);
          if (dp_q[idx_q]) begin
            seg_d[7] = 1'b0;
          end
        end
        if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // State, snapshot and output registers. Reset blanks the display at once
  // and restarts the frame from the snapshot point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      src_q        <= SRC_NONE;
      digits_q     <= '0;
      dp_q         <= '0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      src_q        <= src_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign src_sel    = src_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
// Bench for display_scan_ctrl with NUM_DIGITS=4, DIGIT_CYCLES=4 and
// BLANK_CYCLES=2. A frame-position model derives the expected outputs on
// each rising edge and queues them. A checker pops each entry on the
// following falling edge and compares it with the DUT outputs. While reset
// is held low, the outputs must show the blanked reset values.
module tb_display_scan_ctrl;

  localparam int ND    = 4;
  localparam int DC    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = ND * SLOT;

  logic            clk;
  logic            rst_n;
  logic [3*ND-1:0] live_digits;
  logic            live_valid;
  logic [3*ND-1:0] file_digits;
  logic            file_valid;
  logic [ND-1:0]   dp_mask;
  logic [7:0]      seg_out;
  logic [ND-1:0]   an_out;
  logic [1:0]      src_sel;
  logic            frame_done;

  int compare_count = 0;
  int fail_count    = 0;

  typedef struct {
    logic [7:0]    seg;
    logic [ND-1:0] an;
    logic [1:0]    src;
    logic          fd;
  } exp_t;

  exp_t sb[$];

  logic [7:0] seg_tbl [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .live_digits(live_digits),
    .live_valid (live_valid),
    .file_digits(file_digits),
    .file_valid (file_valid),
    .dp_mask    (dp_mask),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .src_sel    (src_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [3*ND-1:0] ld,
                               input logic fv, input logic [3*ND-1:0] fdig,
                               input logic [ND-1:0] dp);
    live_valid  = lv;
    live_digits = ld;
    file_valid  = fv;
    file_digits = fdig;
    dp_mask     = dp;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference model: the position within the frame is counted from reset
  // release. Outputs after an edge reflect the position before that edge.
  int         m_cnt;
  int         m_p;
  int         m_k;
  int         m_w;
  logic [1:0] m_src;
  logic [3*ND-1:0] m_dig;
  logic [ND-1:0]   m_dp;
  logic [2:0]      m_d;
  exp_t            m_e;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_src = 2'b00;
      m_dig = '0;
      m_dp  = '0;
    end else begin
      m_p = m_cnt % FRAME;
      m_k = m_p / SLOT;
      m_w = m_p % SLOT;
      if (m_p == 0) begin
        m_dp = dp_mask;
        if (file_valid) begin
          m_src = 2'b10;
          m_dig = file_digits;
        end else if (live_valid) begin
          m_src = 2'b01;
          m_dig = live_digits;
        end else begin
          m_src = 2'b00;
          m_dig = '0;
        end
      end
      m_e.src = m_src;
      m_e.fd  = (m_p == FRAME - 1);
      if (m_w < BC) begin
        m_e.seg = 8'hFF;
        m_e.an  = '1;
      end else begin
        m_e.an = ND'(~(ND'(1) << m_k));
        m_d    = m_dig[m_k*3 +: 3];
        if (m_src == 2'b00) m_e.seg = 8'hFF;
        else if (m_dp[m_k]) m_e.seg = seg_tbl[m_d] & 8'h7F;
        else m_e.seg = seg_tbl[m_d];
      end
      sb.push_back(m_e);
      m_cnt++;
    end
  end

  // Checker: compare against the queued expectation, or against the reset
  // values while reset is asserted.
  exp_t c_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      checkOutput("rst_seg", 32'(seg_out), 32'h FF);
      checkOutput("rst_an", 32'(an_out), 32'hF);
      checkOutput("rst_src", 32'(src_sel), 32'h0);
      checkOutput("rst_fd", 32'(frame_done), 32'h0);
    end else if (sb.size() > 0) begin
      c_e = sb.pop_front();
      checkOutput("seg", 32'(seg_out), 32'(c_e.seg));
      checkOutput("an", 32'(an_out), 32'(c_e.an));
      checkOutput("src", 32'(src_sel), 32'(c_e.src));
      checkOutput("frame_done", 32'(frame_done), 32'(c_e.fd));
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, '0, 4'b0000);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    $display("[TB] live digits 1,2,3,4");
    waitCycles(2 * FRAME);

    $display("[TB] both valid, file wins with all 7s");
    applyStimulus(1'b1, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, {4{3'd7}}, 4'b0000);
    waitCycles(2 * FRAME);

    $display("[TB] live only, then file_valid rises mid-frame");
    applyStimulus(1'b1, {3'd0, 3'd5, 3'd6, 3'd1}, 1'b0, '0, 4'b0000);
    waitCycles(FRAME + 8);
    applyStimulus(1'b1, {3'd0, 3'd5, 3'd6, 3'd1}, 1'b1, {3'd2, 3'd3, 3'd4, 3'd5}, 4'b0000);
    waitCycles(2 * FRAME);

    $display("[TB] no valid source, dp mask set");
    applyStimulus(1'b0, {3'd1, 3'd1, 3'd1, 3'd1}, 1'b0, '0, 4'b1111);
    waitCycles(2 * FRAME);

    $display("[TB] decimal point on digit 2");
    applyStimulus(1'b1, {3'd7, 3'd0, 3'd6, 3'd5}, 1'b0, '0, 4'b0100);
    waitCycles(2 * FRAME);

    $display("[TB] reset pulse mid-frame");
    waitCycles(15);
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(FRAME + 6);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
